// File: rtl/mips_run_pkg.sv
// Shared types and helpers for the MIPS run controller.
// State encoding, status codes and the retire popcount.
package mips_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } run_state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam int MAX_CORES = 8;

    function automatic logic [3:0] popcount(
        input logic [MAX_CORES-1:0] v
    );
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// Clearable accumulator that sticks at all ones.
// Used for both the cycle and retirement counts.
module sat_counter
    import mips_run_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] inc,
    output logic [W-1:0] count
);

    logic [W:0] sum;

    // One extra bit catches the carry that means saturation.
    always_comb begin
        sum = {1'b0, count} + {1'b0, inc};
    end

    // Clear wins over accumulate; saturate instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: core reset sequencing, run gating,
// cycle/retire counting and halt/timeout termination.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int RESET_CYCLES = 10,
    parameter int MAX_CYCLES   = 50000,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] halt,
    input  logic [NUM_CORES-1:0] retire,
    output logic                 core_reset,
    output logic                 run,
    output logic                 done,
    output logic [1:0]           status,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     retire_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1) + 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES);
    localparam logic [CNT_W:0] CYC_LIMIT = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [NUM_CORES-1:0] ALL_HALTED = '1;

    logic [1:0]           rst_sync;
    logic                 rst_ok;
    run_state_t           state;
    logic [HOLD_W-1:0]    hold;
    logic                 accept;
    logic                 in_run;
    logic [NUM_CORES-1:0] mask_next;
    logic [CNT_W:0]       cyc_next;
    logic [MAX_CORES-1:0] retire_ext;
    logic [CNT_W-1:0]     retire_inc;

    // Reset asserts immediately but releases two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync[1];

    // Start acceptance and the RUN-cycle exit terms.
    always_comb begin
        accept     = rst_ok && start
                     && (state == IDLE || state == DONE);
        in_run     = rst_ok && (state == RUN);
        mask_next  = halted_mask | halt;
        cyc_next   = {1'b0, cycle_count} + (CNT_W + 1)'(1);
        retire_ext = MAX_CORES'(retire);
        retire_inc = CNT_W'(popcount(retire_ext));
    end

    // Run sequencer with registered control and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold        <= '0;
            core_reset  <= 1'b1;
            run         <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            halted_mask <= '0;
        end else if (rst_ok) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RESET_HOLD;
                        hold        <= HOLD_INIT;
                        core_reset  <= 1'b1;
                        run         <= 1'b0;
                        done        <= 1'b0;
                        status      <= ST_NONE;
                        halted_mask <= '0;
                    end
                end
                RESET_HOLD: begin
                    hold <= hold - HOLD_W'(1);
                    if (hold == HOLD_W'(1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        run        <= 1'b1;
                    end
                end
                RUN: begin
                    halted_mask <= mask_next;
                    if (mask_next == ALL_HALTED) begin
                        state  <= DONE;
                        run    <= 1'b0;
                        done   <= 1'b1;
                        status <= ST_HALT;
                    end else if (cyc_next == CYC_LIMIT) begin
                        state  <= DONE;
                        run    <= 1'b0;
                        done   <= 1'b1;
                        status <= ST_TIMEOUT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (in_run),
        .inc   (CNT_W'(1)),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retires (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (in_run),
        .inc   (retire_inc),
        .count (retire_count)
    );

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: table of runs plus hand sequences
// for reset, halt/timeout tie and counter saturation.
module tb_mips_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: 4 cores, hold 10, budget 100, 32-bit counters
    logic        rst_a, start_a, core_reset_a, run_a, done_a;
    logic [3:0]  halt_a, retire_a, mask_a;
    logic [1:0]  status_a;
    logic [31:0] cyc_a, ret_a;

    // dut_b: 2 cores, hold 2, budget 20
    logic        rst_b, start_b, core_reset_b, run_b, done_b;
    logic [1:0]  halt_b, retire_b, mask_b;
    logic [1:0]  status_b;
    logic [31:0] cyc_b, ret_b;

    // dut_c: 8 cores, hold 1, 4-bit counters
    logic        rst_c, start_c, core_reset_c, run_c, done_c;
    logic [7:0]  halt_c, retire_c, mask_c;
    logic [1:0]  status_c;
    logic [3:0]  cyc_c, ret_c;

    mips_run_ctrl #(
        .NUM_CORES(4), .RESET_CYCLES(10),
        .MAX_CYCLES(100), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .halt(halt_a), .retire(retire_a),
        .core_reset(core_reset_a), .run(run_a), .done(done_a),
        .status(status_a), .halted_mask(mask_a),
        .cycle_count(cyc_a), .retire_count(ret_a)
    );

    mips_run_ctrl #(
        .NUM_CORES(2), .RESET_CYCLES(2),
        .MAX_CYCLES(20), .CNT_W(32)
    ) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .halt(halt_b), .retire(retire_b),
        .core_reset(core_reset_b), .run(run_b), .done(done_b),
        .status(status_b), .halted_mask(mask_b),
        .cycle_count(cyc_b), .retire_count(ret_b)
    );

    mips_run_ctrl #(
        .NUM_CORES(8), .RESET_CYCLES(1),
        .MAX_CYCLES(100), .CNT_W(4)
    ) dut_c (
        .clk(clk), .reset(rst_c), .start(start_c),
        .halt(halt_c), .retire(retire_c),
        .core_reset(core_reset_c), .run(run_c), .done(done_c),
        .status(status_c), .halted_mask(mask_c),
        .cycle_count(cyc_c), .retire_count(ret_c)
    );

    typedef struct {
        int         h0, h1, h2, h3;
        logic [3:0] retire;
        int         start_at;
        logic [1:0] status;
        int         cycles;
        int         retires;
        logic [3:0] mask;
    } vec_t;

    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] cycles;
        logic [31:0] retires;
        logic [7:0]  mask;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string tag,
                            input logic d,
                            input logic [1:0] st,
                            input logic [31:0] cy,
                            input logic [31:0] rt,
                            input logic [7:0] mk);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_done"}, 64'(d), 64'd1);
            check({tag, "_status"}, 64'(st), 64'(e.status));
            check({tag, "_cycles"}, 64'(cy), 64'(e.cycles));
            check({tag, "_retires"}, 64'(rt), 64'(e.retires));
            check({tag, "_mask"}, 64'(mk), 64'(e.mask));
        end
    endtask

    task automatic run_vec_a(input vec_t v);
        int         k;
        int         hold_n;
        logic [3:0] h;
        logic [3:0] exp_mask;
        sb.push_back('{v.status, 32'(v.cycles),
                       32'(v.retires), 8'(v.mask)});
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_clr_done", 64'(done_a), 64'd0);
        check("a_clr_status", 64'(status_a), 64'd0);
        check("a_clr_cyc", 64'(cyc_a), 64'd0);
        check("a_clr_ret", 64'(ret_a), 64'd0);
        check("a_clr_mask", 64'(mask_a), 64'd0);
        hold_n = 0;
        while (!run_a && hold_n < 40) begin
            if (core_reset_a) hold_n++;
            @(negedge clk);
        end
        check("a_hold_cycles", 64'(hold_n), 64'd10);
        check("a_core_reset_low", 64'(core_reset_a), 64'd0);
        k = 0;
        exp_mask = '0;
        while (run_a && k < 300) begin
            k++;
            if (k == 1 || k == 50) begin
                check("a_cyc_run", 64'(cyc_a), 64'(k - 1));
            end
            check("a_mask_run", 64'(mask_a), 64'(exp_mask));
            h = '0;
            if (v.h0 == k) h[0] = 1'b1;
            if (v.h1 == k) h[1] = 1'b1;
            if (v.h2 == k) h[2] = 1'b1;
            if (v.h3 == k) h[3] = 1'b1;
            halt_a   = h;
            retire_a = v.retire;
            start_a  = (k == v.start_at);
            exp_mask = exp_mask | h;
            @(negedge clk);
        end
        halt_a   = '0;
        retire_a = '0;
        start_a  = 1'b0;
        check("a_run_cycles", 64'(k), 64'(v.cycles));
        check("a_done_core_reset", 64'(core_reset_a), 64'd0);
        sb_check("a", done_a, status_a, cyc_a, ret_a, 8'(mask_a));
    endtask

    task automatic run_case_b(input int hk,
                              input logic [1:0] hv,
                              input logic [1:0] est,
                              input int ecy,
                              input logic [1:0] emk);
        int k;
        int w;
        sb.push_back('{est, 32'(ecy), 32'd0, 8'(emk)});
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        w = 0;
        while (!run_b && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("b_hold_cycles", 64'(w), 64'd2);
        k = 0;
        while (run_b && k < 100) begin
            k++;
            halt_b = (k == hk) ? hv : 2'b00;
            @(negedge clk);
        end
        halt_b = '0;
        check("b_run_cycles", 64'(k), 64'(ecy));
        sb_check("b", done_b, status_b, cyc_b, ret_b, 8'(mask_b));
    endtask

    task automatic run_case_c();
        int         k;
        int         w;
        logic [3:0] exp_ret;
        sb.push_back('{2'b01, 32'd4, 32'd15, 8'hFF});
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        w = 0;
        while (!run_c && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("c_hold_cycles", 64'(w), 64'd1);
        k = 0;
        exp_ret = '0;
        while (run_c && k < 20) begin
            k++;
            check("c_ret_run", 64'(ret_c), 64'(exp_ret));
            retire_c = 8'h1F;
            halt_c   = (k == 4) ? 8'hFF : 8'h00;
            exp_ret  = (exp_ret > 4'd10) ? 4'd15 : exp_ret + 4'd5;
            @(negedge clk);
        end
        retire_c = '0;
        halt_c   = '0;
        check("c_run_cycles", 64'(k), 64'd4);
        sb_check("c", done_c, status_c, 32'(cyc_c), 32'(ret_c), mask_c);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        vecs[0] = '{40, 40, 40, 40, 4'b0001, 0, 2'b01, 40, 40, 4'b1111};
        vecs[1] = '{0, 0, 0, 0, 4'b0000, 0, 2'b10, 100, 0, 4'b0000};
        vecs[2] = '{3, 7, 7, 12, 4'b1111, 0, 2'b01, 12, 48, 4'b1111};
        vecs[3] = '{5, 5, 5, 5, 4'b0010, 2, 2'b01, 5, 5, 4'b1111};
        vecs[4] = '{10, 10, 0, 0, 4'b0101, 0, 2'b10, 100, 200, 4'b0011};

        rst_a = 1'b0; start_a = 1'b0; halt_a = '0; retire_a = '0;
        rst_b = 1'b0; start_b = 1'b0; halt_b = '0; retire_b = '0;
        rst_c = 1'b0; start_c = 1'b0; halt_c = '0; retire_c = '0;

        repeat (3) @(negedge clk);
        check("rst_core_reset", 64'(core_reset_a), 64'd1);
        check("rst_run", 64'(run_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_status", 64'(status_a), 64'd0);
        check("rst_mask", 64'(mask_a), 64'd0);
        check("rst_cyc", 64'(cyc_a), 64'd0);
        check("rst_ret", 64'(ret_a), 64'd0);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_run", 64'(run_a), 64'd0);
        check("idle_done", 64'(done_a), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec_a(vecs[i]);
        end

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        w = 0;
        while (!run_a && w < 40) begin
            w++;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check("mid_cyc", 64'(cyc_a), 64'd30);
        check("mid_run", 64'(run_a), 64'd1);
        #2;
        rst_a = 1'b0;
        #1;
        check("arst_core_reset", 64'(core_reset_a), 64'd1);
        check("arst_run", 64'(run_a), 64'd0);
        check("arst_done", 64'(done_a), 64'd0);
        check("arst_status", 64'(status_a), 64'd0);
        check("arst_mask", 64'(mask_a), 64'd0);
        check("arst_cyc", 64'(cyc_a), 64'd0);
        check("arst_ret", 64'(ret_a), 64'd0);
        @(negedge clk);
        rst_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        check("sync_start_ignored", 64'(run_a), 64'd0);
        run_vec_a(vecs[0]);

        run_case_b(20, 2'b11, 2'b01, 20, 2'b11);
        run_case_b(20, 2'b01, 2'b10, 20, 2'b01);
        run_case_b(19, 2'b11, 2'b01, 19, 2'b11);

        run_case_c();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
